// File: rtl/kalman_feeder_if.sv
// Sample/result bus between the ADC capture side, the feeder and the Kalman filter.
// Ports: adc_* push side, en_kalman/origin_data filter start, filter_finish/filtered_data
// filter result, out_* downstream result, busy/level/overflow/timeout_err status.
interface kalman_feeder_if #(
  parameter int AW = 3
);
  logic               adc_valid;
  logic signed [12:0] adc_data;
  logic               en_kalman;
  logic signed [12:0] origin_data;
  logic               filter_finish;
  logic signed [12:0] filtered_data;
  logic               out_valid;
  logic signed [12:0] out_data;
  logic               busy;
  logic [AW:0]        level;
  logic               overflow;
  logic               timeout_err;

  // master: the feeder itself
  modport master (
    input  adc_valid, adc_data, filter_finish, filtered_data,
    output en_kalman, origin_data, out_valid, out_data,
    busy, level, overflow, timeout_err
  );

  // slave: ADC source, filter and downstream consumer
  modport slave (
    output adc_valid, adc_data, filter_finish, filtered_data,
    input  en_kalman, origin_data, out_valid, out_data,
    busy, level, overflow, timeout_err
  );
endinterface

// File: rtl/kalman_feeder.sv
// Buffers ADC samples in a FIFO, strobes them one at a time into the Kalman filter, forwards results.
// Latency: adc_valid (a) -> en_kalman a+2 -> out_valid a+10 with an 8-cycle filter; all outputs registered.
// Backpressure: none upstream -- a sample arriving at a full FIFO is dropped and flagged on overflow.
// Ports: clk, rst (sync, active-high), bus (kalman_feeder_if.master; see interface for signal list).
module kalman_feeder #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  kalman_feeder_if.master bus
);

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic signed [12:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [AW:0]        level_q, level_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               en_q, en_d;
  logic signed [12:0] origin_q, origin_d;
  logic               out_valid_q, out_valid_d;
  logic signed [12:0] out_data_q, out_data_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;

  logic               push, pop;

  // Full is judged on the occupancy at the start of the cycle, so a pop in
  // the same cycle does not make room for the incoming sample.
  assign push       = bus.adc_valid && (level_q != FULL);
  assign overflow_d = bus.adc_valid && (level_q == FULL);
  assign level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    en_d        = 1'b0;
    origin_d    = origin_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        // filter_finish here is stale and deliberately ignored
        if (level_q != '0) begin
          pop      = 1'b1;
          en_d     = 1'b1;
          origin_d = mem[rd_ptr];
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.filter_finish) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.filtered_data;
          if (level_q != '0) begin
            // back-to-back: the filter is ready again the cycle after finish
            pop      = 1'b1;
            en_d     = 1'b1;
            origin_d = mem[rd_ptr];
            cnt_d    = '0;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == LAST) begin
          // abandon the outstanding sample; the pulse lands TIMEOUT cycles after en_kalman
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      origin_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      origin_q    <= origin_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.adc_data;
  end

  assign bus.en_kalman   = en_q;
  assign bus.origin_data = origin_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.busy        = busy_q;
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_kalman_feeder.sv
// Testbench for kalman_feeder: directed stimulus, expected events queued in a scoreboard,
// a negedge monitor pops and compares each en_kalman/out_valid/overflow/timeout_err pulse.
// An 8-cycle filter model answers strobes with origin_data-10 when enabled.
module tb_kalman_feeder;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 64;

  typedef struct {
    int cyc;
    int val;
  } evt_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   t0  = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  evt_t en_q[$];
  evt_t out_q[$];
  evt_t ovf_q[$];
  evt_t to_q[$];

  logic               filt_on;
  logic               fin_pend;
  int                 fin_cyc;
  logic               model_fin;
  logic signed [12:0] model_dat;
  logic               stray_fin;
  logic signed [12:0] stray_dat;

  int                 s3[8];
  int                 o3[7];
  logic signed [12:0] bd[4];
  int                 be[4];
  int                 bo[4];

  kalman_feeder_if #(.AW(AW)) bus ();

  kalman_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.filter_finish = model_fin | stray_fin;
  assign bus.filtered_data = model_fin ? model_dat : stray_dat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Filter model: strobe in cycle k -> filter_finish in k+7.
  initial begin
    fin_pend  = 1'b0;
    fin_cyc   = 0;
    model_fin = 1'b0;
    model_dat = '0;
    forever begin
      @(negedge clk);
      if (rst) fin_pend = 1'b0;
      else if (bus.en_kalman && filt_on) begin
        fin_pend  = 1'b1;
        fin_cyc   = cyc + 7;
        model_dat = bus.origin_data - 13'sd10;
      end
      @(posedge clk);
      #1;
      model_fin = fin_pend && (cyc == fin_cyc);
      if (model_fin) fin_pend = 1'b0;
    end
  end

  task automatic cmp_evt(input string name, input evt_t e, input int val);
    n_cmp = n_cmp + 1;
    if (e.cyc != cyc || e.val != val) begin
      n_err = n_err + 1;
      $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d",
               name, cyc, val, e.cyc, e.val);
    end
  endtask

  task automatic unexp(input string name, input int val);
    n_cmp = n_cmp + 1;
    n_err = n_err + 1;
    $display("FAIL %s: unexpected pulse at cycle %0d value %0d", name, cyc, val);
  endtask

  // Monitor: every output pulse must match the head of its queue.
  initial forever begin
    evt_t e;
    @(negedge clk);
    if (!rst) begin
      if (bus.en_kalman === 1'b1) begin
        if (en_q.size() == 0) unexp("en_kalman", int'(bus.origin_data));
        else begin e = en_q.pop_front(); cmp_evt("en_kalman", e, int'(bus.origin_data)); end
      end
      if (bus.out_valid === 1'b1) begin
        if (out_q.size() == 0) unexp("out_valid", int'(bus.out_data));
        else begin e = out_q.pop_front(); cmp_evt("out_valid", e, int'(bus.out_data)); end
      end
      if (bus.overflow === 1'b1) begin
        if (ovf_q.size() == 0) unexp("overflow", 0);
        else begin e = ovf_q.pop_front(); cmp_evt("overflow", e, 0); end
      end
      if (bus.timeout_err === 1'b1) begin
        if (to_q.size() == 0) unexp("timeout_err", 0);
        else begin e = to_q.pop_front(); cmp_evt("timeout_err", e, 0); end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // advance to #1 after the edge that starts relative cycle c
  task automatic go(input int c);
    while (cyc < t0 + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_at(input int c, input logic signed [12:0] v);
    go(c);
    bus.adc_valid = 1'b1;
    bus.adc_data  = v;
    go(c + 1);
    bus.adc_valid = 1'b0;
  endtask

  task automatic stray_at(input int c, input logic signed [12:0] v);
    go(c);
    stray_fin = 1'b1;
    stray_dat = v;
    go(c + 1);
    stray_fin = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " en_kalman"},   int'(bus.en_kalman),   0);
    chk({tag, " origin_data"}, int'(bus.origin_data), 0);
    chk({tag, " out_valid"},   int'(bus.out_valid),   0);
    chk({tag, " out_data"},    int'(bus.out_data),    0);
    chk({tag, " busy"},        int'(bus.busy),        0);
    chk({tag, " level"},       int'(bus.level),       0);
    chk({tag, " overflow"},    int'(bus.overflow),    0);
    chk({tag, " timeout_err"}, int'(bus.timeout_err), 0);
  endtask

  task automatic start_scn();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    t0  = cyc;
    check_reset_vals("reset");
  endtask

  initial begin
    rst           = 1'b1;
    filt_on       = 1'b1;
    stray_fin     = 1'b0;
    stray_dat     = '0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    s3 = '{-500, -400, -300, -200, -100, 0, 100, 200};
    o3 = '{-510, -410, -310, -210, -110, -10, 90};
    bd = '{-13'sd5, 13'sd0, 13'sd7, 13'h1FFF};
    be = '{-5, 0, 7, -1};
    bo = '{-15, -10, -3, -11};

    // single sample
    start_scn();
    filt_on = 1'b1;
    en_q.push_back('{t0 + 7, 100});
    out_q.push_back('{t0 + 15, 90});
    push_at(5, 13'sd100);
    go(6);  chk("single level", int'(bus.level), 1);
    go(10); chk("single busy",  int'(bus.busy), 1);
    go(16); chk("single busy end", int'(bus.busy), 0);
    chk("single level end", int'(bus.level), 0);
    go(20);

    // burst of four against the 8-cycle filter
    start_scn();
    for (int i = 0; i < 4; i++) begin
      en_q.push_back('{t0 + 4 + 8 * i, be[i]});
      out_q.push_back('{t0 + 12 + 8 * i, bo[i]});
    end
    for (int i = 0; i < 4; i++) push_at(2 + i, bd[i]);
    go(6);  chk("burst level c6",  int'(bus.level), 3);
    go(12); chk("burst level c12", int'(bus.level), 2);
    go(20); chk("burst level c20", int'(bus.level), 1);
    go(28); chk("burst level c28", int'(bus.level), 0);
    go(37); chk("burst busy end",  int'(bus.busy), 0);
    go(40);

    // overflow, full with simultaneous pop, timeout, stale finish
    start_scn();
    filt_on = 1'b0;
    en_q.push_back('{t0 + 4, 11});
    for (int j = 0; j < 8; j++) en_q.push_back('{t0 + 21 + 8 * j, s3[j]});
    en_q.push_back('{t0 + 142, 999});
    out_q.push_back('{t0 + 21, 55});
    for (int j = 0; j < 7; j++) out_q.push_back('{t0 + 29 + 8 * j, o3[j]});
    out_q.push_back('{t0 + 150, 989});
    ovf_q.push_back('{t0 + 14, 0});
    ovf_q.push_back('{t0 + 15, 0});
    ovf_q.push_back('{t0 + 21, 0});
    to_q.push_back('{t0 + 141, 0});
    push_at(2, 13'sd11);
    for (int j = 0; j < 10; j++) push_at(5 + j, 13'((j * 100) - 500));
    go(16); chk("full level", int'(bus.level), 8);
    go(20); chk("full level before pop", int'(bus.level), 8);
    filt_on       = 1'b1;
    stray_fin     = 1'b1;
    stray_dat     = 13'sd55;
    bus.adc_valid = 1'b1;
    bus.adc_data  = 13'sd1234;
    go(21);
    stray_fin     = 1'b0;
    bus.adc_valid = 1'b0;
    chk("full pop level", int'(bus.level), 7);
    go(75); filt_on = 1'b0;
    push_at(80, 13'sd999);
    go(100); filt_on = 1'b1;
    go(141);
    chk("timeout busy", int'(bus.busy), 0);
    chk("timeout level", int'(bus.level), 1);
    stray_at(141, 13'sd333);
    go(152); chk("drain busy", int'(bus.busy), 0);
    chk("drain level", int'(bus.level), 0);
    stray_at(160, 13'sd444);
    go(165);

    // reset in the middle of a wait
    start_scn();
    filt_on = 1'b0;
    en_q.push_back('{t0 + 4, 1});
    for (int i = 0; i < 4; i++) push_at(2 + i, 13'(i + 1));
    go(8);  chk("mid level", int'(bus.level), 3);
    chk("mid busy", int'(bus.busy), 1);
    go(10); rst = 1'b1;
    go(11); check_reset_vals("midrst");
    go(12); rst = 1'b0;
    stray_at(14, 13'sd42);
    go(18); chk("post rst level", int'(bus.level), 0);
    chk("post rst busy", int'(bus.busy), 0);
    go(22);

    chk("en_q leftover",  en_q.size(),  0);
    chk("out_q leftover", out_q.size(), 0);
    chk("ovf_q leftover", ovf_q.size(), 0);
    chk("to_q leftover",  to_q.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
